ps2_rx: RTL
===========

# ps2_rx

PS/2 device-to-host receiver between the PS/2 PMOD pins and the SoC input port. Synchronises raw PS/2 clock and data, decodes 11-bit frames on falling clock edges, checks framing, and queues received bytes in a small FIFO that firmware drains. Host-side inhibit (SoC pulling PS/2 clock low) is honoured by aborting any partial frame.

## Interface
- `DEPTH`, 4: FIFO depth in bytes; power of two, 2..16.
- `TIMEOUT_CYCLES`, 5000: `clk_core` cycles without a falling edge, mid-frame, before the frame is abandoned; ≥2.
- `clk_core` in 1: sole clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `inhibit` in 1: host is driving PS/2 clock low; abort and ignore edges while high.
- `rd` in 1: pop head byte when `valid`.
- `data` out 8: FIFO head byte; 0 when empty.
- `valid` out 1: FIFO not empty.
- `overrun` out 1: sticky; byte dropped because FIFO full.
- `frame_err` out 1: sticky; bad stop bit or, with parity enabled, bad parity.
- `clear_err` in 1: clears `overrun` and `frame_err`.

## Operation
- Input sync: `ps2_clk`, `ps2_data` each through two flops (reset value 1), then a third flop on clock for edge detect. Falling edge `fe` = prev 1, current 0. Data sampled = synchronised `ps2_data` in the `fe` cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fe` with data 0 (start bit) → DATA, bit count 0, parity accumulator 0. `fe` with data 1 is ignored (glitch).
  - DATA: on `fe`, shift data into bit 7 of shift register (LSB first); after 8th bit → PARITY.
  - PARITY: on `fe`, latch parity bit → STOP.
  - STOP: on `fe`: stop=1 and parity OK → push byte; otherwise set `frame_err`, discard. Either way → IDLE.
- Parity OK: XOR of 8 data bits and parity bit = 1 (odd).
- Timeout: counter resets on every `fe` and in IDLE; reaching `TIMEOUT_CYCLES` outside IDLE → IDLE, partial frame dropped, no flag.
- `inhibit` high: FSM forced to IDLE, timeout counter cleared, `fe` ignored; no flag. FIFO contents untouched.
- FIFO: circular buffer, `log2(DEPTH)+1`-bit read/write pointers, wrap modulo DEPTH; full when pointers differ only in MSB.
- Push while full: byte dropped, `overrun` set. Push and `rd` in the same cycle while full: both occur, no overrun. `rd` while empty: ignored.
- Sticky flags: set and `clear_err` in the same cycle → set wins.
- Reset: FSM IDLE, FIFO empty, `valid`=0, `data`=0, `overrun`=0, `frame_err`=0, sync flops 1. Reset mid-frame discards the frame.

## Timing
- Pin-to-`fe` latency: 3 `clk_core` cycles after the pin falls.
- Push takes effect on the edge ending the stop-bit `fe` cycle; `valid` and `data` update that edge (registered, no combinational path from pins).
- `rd` sampled on a rising edge; `data` shows the next entry, and `valid` drops if the FIFO becomes empty, on that same edge.
- Throughput: one pop per cycle; one push per frame (11 `fe`s).
- Minimum PS/2 clock phase for reliable capture: 4 `clk_core` cycles high and low.

## Configuration
- `PS2_RX_PARITY_EN` defined: parity checked as above; failing frames set `frame_err` and are not pushed.
- Undefined: parity bit still consumed in PARITY state but ignored; only stop bit = 0 sets `frame_err`; parity logic absent.

## Test plan
- Frame 0x1C (start 0, data LSB-first, parity 0, stop 1), 12 kHz PS/2 clock → `valid`=1, `data`=0x1C within 1 cycle of last `fe`; `rd` → `valid`=0, `data`=0.
- Frame 0x1C with parity 1, macro defined → no push, `frame_err`=1; macro undefined → 0x1C pushed, `frame_err`=0.
- Frame with stop bit 0 → no push, `frame_err`=1; `clear_err` pulse → 0; `clear_err` coinciding with another bad stop → stays 1.
- DEPTH=4, five frames 0x01..0x05 with no reads → reads return 0x01..0x04, `overrun`=1; repeat with `rd` asserted in the 5th push cycle → no overrun, 0x05 read last.
- Stop clock after 4 data bits for `TIMEOUT_CYCLES` → FSM IDLE; next full frame 0xAA received correctly, no flags.
- Assert `inhibit` mid-frame, release, send 0x5A → only 0x5A queued; assert `reset_n`=0 mid-frame → all outputs 0, FIFO empty.

Source files
------------

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with framing check and byte FIFO.
// Define PS2_RX_PARITY_EN to reject frames with bad odd parity.
module ps2_rx #(
  parameter int DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk_core,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       inhibit,
  input  logic       rd,
  input  logic       clear_err,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t        state;
  logic [2:0]    clk_s;
  logic [1:0]    dat_s;
  logic [2:0]    cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tmo;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          fe, bit_in, stop_ev, par_ok, push, pop, full, wr_en;
  always_ff @(posedge clk_core or negedge reset_n)
    if (!reset_n) begin
      clk_s <= '1;
      dat_s <= '1;
    end else begin
      clk_s <= {clk_s[1:0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
    end
  assign fe      = clk_s[2] & ~clk_s[1];
  assign bit_in  = dat_s[1];
  assign stop_ev = fe && !inhibit && state == STOP;
`ifdef PS2_RX_PARITY_EN
  logic par;
  // Running XOR of data and parity bits; odd parity leaves it at 1.
  always_ff @(posedge clk_core or negedge reset_n)
    if (!reset_n) par <= 1'b0;
    else if (fe && !inhibit) par <= (state == IDLE) ? 1'b0 : par ^ bit_in;
  assign par_ok = par;
`else
  assign par_ok = 1'b1;
`endif
  always_ff @(posedge clk_core or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      tmo   <= '0;
    end else if (inhibit) begin
      state <= IDLE;
      tmo   <= '0;
    end else begin
      tmo <= (fe || state == IDLE) ? '0 : tmo + 1'b1;
      if (fe)
        case (state)
          IDLE:    if (!bit_in) begin
                     state <= DATA;
                     cnt   <= '0;
                   end
          DATA:    begin
                     shreg <= {bit_in, shreg[7:1]};
                     cnt   <= cnt + 1'b1;
                     if (cnt == 3'd7) state <= PARITY;
                   end
          PARITY:  state <= STOP;
          default: state <= IDLE;
        endcase
      else if (state != IDLE && tmo == TW'(TIMEOUT_CYCLES - 1))
        state <= IDLE;
    end
  assign push  = stop_ev && bit_in && par_ok;
  assign valid = wr_ptr != rd_ptr;
  assign pop   = rd && valid;
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign data  = valid ? mem[rd_ptr[AW-1:0]] : 8'd0;
  always_ff @(posedge clk_core or negedge reset_n)
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      overrun   <= (push && full && !pop) || (overrun && !clear_err);
      frame_err <= (stop_ev && !(bit_in && par_ok)) || (frame_err && !clear_err);
    end
  always_ff @(posedge clk_core)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
endmodule
